// File: rtl/write_coalesce_buffer.sv
// rtl/write_coalesce_buffer.sv - multi-slot write-coalescing buffer in front of the CCI write request channel
//
// Purpose: merges word stores into NUM_SLOTS cache-line slots. A line is issued
// when it fills, on a flush, or when its slot is needed. Full-line direct writes
// pass straight through. Issue is throttled by wr_req_almostfull and by a
// credit counter of issued-but-unacknowledged writes.
//
// Optional feature macro: WCB_WMASK_OUT_EN adds wr_req_wmask, the per-word mask
// registered alongside wr_req_en (all ones for direct writes, 0 when idle).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_req_addr/mdata/data/en  registered line write issue (one per cycle)
//   wr_req_almostfull   channel backpressure, blocks issue while high
//   wr_rsp0/1_valid     write responses, each returns one credit (mdata unused)
//   wr_en, wr_direct    word store / full-line store request, taken when wr_ready
//   wr_now              flush-all pulse
//   wr_addr             {line, word offset}
//   wr_data, wr_mdata   store data (word in low bits, or full line) and metadata
//   wr_ready            combinational acceptance for the current request
//   wr_valid            registered pulse per accepted request
//   wr_real_valid       any write response this cycle
//   outstanding         current credit usage
//   idle                nothing buffered, not flushing, nothing in flight
module write_coalesce_buffer #(
  parameter int ADDR_LMT        = 20,
  parameter int MDATA           = 14,
  parameter int CACHE_WIDTH     = 512,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_SLOTS       = 4,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  output logic [ADDR_LMT-1:0]                                  wr_req_addr,
  output logic [MDATA-1:0]                                     wr_req_mdata,
  output logic [CACHE_WIDTH-1:0]                               wr_req_data,
  output logic                                                 wr_req_en,
  input  logic                                                 wr_req_almostfull,
  input  logic                                                 wr_rsp0_valid,
  input  logic [MDATA-1:0]                                     wr_rsp0_mdata,
  input  logic                                                 wr_rsp1_valid,
  input  logic [MDATA-1:0]                                     wr_rsp1_mdata,
  input  logic                                                 wr_en,
  input  logic                                                 wr_direct,
  input  logic                                                 wr_now,
  input  logic [ADDR_LMT+$clog2(CACHE_WIDTH/DATA_WIDTH)-1:0]   wr_addr,
  input  logic [CACHE_WIDTH-1:0]                               wr_data,
  input  logic [MDATA-1:0]                                     wr_mdata,
  output logic                                                 wr_ready,
  output logic                                                 wr_valid,
  output logic                                                 wr_real_valid,
  output logic [$clog2(MAX_OUTSTANDING):0]                     outstanding,
`ifdef WCB_WMASK_OUT_EN
  output logic [CACHE_WIDTH/DATA_WIDTH-1:0]                    wr_req_wmask,
`endif
  output logic                                                 idle
);
  localparam int WPL    = CACHE_WIDTH / DATA_WIDTH;
  localparam int OFF_W  = $clog2(WPL);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [NUM_SLOTS-1:0]   valid_q, valid_d;
  logic [ADDR_LMT-1:0]    line_q  [NUM_SLOTS];
  logic [ADDR_LMT-1:0]    line_d  [NUM_SLOTS];
  logic [CACHE_WIDTH-1:0] data_q  [NUM_SLOTS];
  logic [CACHE_WIDTH-1:0] data_d  [NUM_SLOTS];
  logic [WPL-1:0]         mask_q  [NUM_SLOTS];
  logic [WPL-1:0]         mask_d  [NUM_SLOTS];
  logic [MDATA-1:0]       mdata_q [NUM_SLOTS];
  logic [MDATA-1:0]       mdata_d [NUM_SLOTS];
  logic [SLOT_W-1:0]      victim_q, victim_d;
  logic [CNT_W-1:0]       out_q, out_d;

  logic                   req_en_q, req_en_d;
  logic [ADDR_LMT-1:0]    req_addr_q, req_addr_d;
  logic [MDATA-1:0]       req_mdata_q, req_mdata_d;
  logic [CACHE_WIDTH-1:0] req_data_q, req_data_d;
  logic [WPL-1:0]         req_mask_q, req_mask_d;
  logic                   wr_valid_q;

  logic [ADDR_LMT-1:0]    line_in;
  logic [OFF_W-1:0]       off_in;
  logic                   run, can_issue;
  logic                   hit_any, free_any, full_any, pend_any;
  logic [SLOT_W-1:0]      hit_idx, free_idx, full_idx, pend_idx, tgt_idx;
  logic                   issue_direct, issue_slot, victim_issue;
  logic [SLOT_W-1:0]      issue_idx;
  logic                   direct_ok, word_ok;
  int                     cnt;
  logic                   unused_rsp_mdata;

  assign line_in   = wr_addr[ADDR_LMT+OFF_W-1:OFF_W];
  assign off_in    = wr_addr[OFF_W-1:0];
  assign run       = (state_q == ST_RUN);
  assign can_issue = !wr_req_almostfull && (out_q < CNT_W'(MAX_OUTSTANDING));
  assign unused_rsp_mdata = ^{wr_rsp0_mdata, wr_rsp1_mdata};

  // Slot lookup; descending scan so the lowest matching index wins.
  always_comb begin
    hit_any  = 1'b0; hit_idx  = '0;
    free_any = 1'b0; free_idx = '0;
    full_any = 1'b0; full_idx = '0;
    pend_any = 1'b0; pend_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (valid_q[i] && line_q[i] == line_in) begin hit_any = 1'b1; hit_idx = SLOT_W'(i); end
      if (!valid_q[i])                        begin free_any = 1'b1; free_idx = SLOT_W'(i); end
      if (valid_q[i] && (&mask_q[i]))         begin full_any = 1'b1; full_idx = SLOT_W'(i); end
      if (valid_q[i])                         begin pend_any = 1'b1; pend_idx = SLOT_W'(i); end
    end
  end

  // A direct write to a buffered line must wait until that line has gone out,
  // otherwise the older partial data would land after the newer full line.
  assign direct_ok = wr_direct && run && can_issue && !hit_any;

  // Issue selection, at most one per cycle.
  always_comb begin
    issue_direct = 1'b0;
    issue_slot   = 1'b0;
    issue_idx    = '0;
    victim_issue = 1'b0;
    if (direct_ok) begin
      issue_direct = 1'b1;
    end else if (can_issue) begin
      if (full_any) begin
        issue_slot = 1'b1; issue_idx = full_idx;
      end else if (!run && pend_any) begin
        issue_slot = 1'b1; issue_idx = pend_idx;
      end else if (run && wr_direct && hit_any) begin
        // evict the buffered copy of the line a stalled direct write targets
        issue_slot = 1'b1; issue_idx = hit_idx;
      end else if (run && wr_en && !hit_any && !free_any) begin
        issue_slot = 1'b1; issue_idx = victim_q; victim_issue = 1'b1;
      end
    end
  end

  assign word_ok  = wr_en && run &&
                    (hit_any ? !(issue_slot && issue_idx == hit_idx) : free_any);
  assign wr_ready = wr_direct ? direct_ok : (wr_en ? word_ok : run);
  assign tgt_idx  = hit_any ? hit_idx : free_idx;

  // Slot next state: invalidate the issued slot, merge or allocate the store.
  always_comb begin
    valid_d  = valid_q;
    line_d   = line_q;
    data_d   = data_q;
    mask_d   = mask_q;
    mdata_d  = mdata_q;
    victim_d = victim_q + SLOT_W'(victim_issue);
    if (issue_slot) valid_d[issue_idx] = 1'b0;
    if (word_ok) begin
      if (!hit_any) begin
        valid_d[tgt_idx] = 1'b1;
        line_d[tgt_idx]  = line_in;
        mask_d[tgt_idx]  = '0;
        data_d[tgt_idx]  = '0;   // unwritten words of a partial line go out as zero
      end
      mask_d[tgt_idx][off_in] = 1'b1;
      data_d[tgt_idx][off_in*DATA_WIDTH +: DATA_WIDTH] = wr_data[DATA_WIDTH-1:0];
      mdata_d[tgt_idx] = wr_mdata;
    end
  end

  // Request register inputs; zero whenever nothing is issued.
  always_comb begin
    req_en_d    = issue_direct || issue_slot;
    req_addr_d  = '0;
    req_mdata_d = '0;
    req_data_d  = '0;
    req_mask_d  = '0;
    if (issue_direct) begin
      req_addr_d  = line_in;
      req_mdata_d = wr_mdata;
      req_data_d  = wr_data;
      req_mask_d  = '1;
    end else if (issue_slot) begin
      req_addr_d  = line_q[issue_idx];
      req_mdata_d = mdata_q[issue_idx];
      req_data_d  = data_q[issue_idx];
      req_mask_d  = mask_q[issue_idx];
    end
  end

  // FSM: leave FLUSH once the selection in this cycle empties the buffer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (wr_now && (|valid_d)) state_d = ST_FLUSH;
      ST_FLUSH: if (~|valid_d)            state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Credit counter, clamped to [0, MAX_OUTSTANDING].
  always_comb begin
    cnt = int'(out_q) + int'(req_en_d) - int'(wr_rsp0_valid) - int'(wr_rsp1_valid);
    if (cnt < 0)               cnt = 0;
    if (cnt > MAX_OUTSTANDING) cnt = MAX_OUTSTANDING;
    out_d = CNT_W'(cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      valid_q  <= '0;
      victim_q <= '0;
      out_q    <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        line_q[i]  <= '0;
        data_q[i]  <= '0;
        mask_q[i]  <= '0;
        mdata_q[i] <= '0;
      end
      req_en_q    <= 1'b0;
      req_addr_q  <= '0;
      req_mdata_q <= '0;
      req_data_q  <= '0;
      req_mask_q  <= '0;
      wr_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      victim_q    <= victim_d;
      out_q       <= out_d;
      line_q      <= line_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      mdata_q     <= mdata_d;
      req_en_q    <= req_en_d;
      req_addr_q  <= req_addr_d;
      req_mdata_q <= req_mdata_d;
      req_data_q  <= req_data_d;
      req_mask_q  <= req_mask_d;
      wr_valid_q  <= word_ok || direct_ok;
    end
  end

  assign wr_req_en     = req_en_q;
  assign wr_req_addr   = req_addr_q;
  assign wr_req_mdata  = req_mdata_q;
  assign wr_req_data   = req_data_q;
  assign wr_valid      = wr_valid_q;
  assign wr_real_valid = wr_rsp0_valid | wr_rsp1_valid;
  assign outstanding   = out_q;
  assign idle          = (~|valid_q) && run && (out_q == '0);
`ifdef WCB_WMASK_OUT_EN
  assign wr_req_wmask  = req_mask_q;
`else
  logic unused_req_mask;
  assign unused_req_mask = ^req_mask_q;
`endif

endmodule

// File: tb/tb_write_coalesce_buffer.sv
// tb/tb_write_coalesce_buffer.sv - directed self-checking bench for write_coalesce_buffer
module tb_write_coalesce_buffer;
  localparam int AW = 20, MW = 14, CW = 512, DW = 32, WPL = 16, OW = 4;
  localparam int MAXO = 2, CNTW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] wr_req_addr;
  logic [MW-1:0] wr_req_mdata;
  logic [CW-1:0] wr_req_data;
  logic          wr_req_en, wr_req_almostfull;
  logic          wr_rsp0_valid, wr_rsp1_valid;
  logic [MW-1:0] wr_rsp0_mdata, wr_rsp1_mdata;
  logic          wr_en, wr_direct, wr_now;
  logic [AW+OW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic [MW-1:0] wr_mdata;
  logic          wr_ready, wr_valid, wr_real_valid, idle;
  logic [CNTW-1:0] outstanding;
`ifdef WCB_WMASK_OUT_EN
  logic [WPL-1:0] wr_req_wmask;
`endif

  write_coalesce_buffer #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
    .wr_req_en(wr_req_en), .wr_req_almostfull(wr_req_almostfull),
    .wr_rsp0_valid(wr_rsp0_valid), .wr_rsp0_mdata(wr_rsp0_mdata),
    .wr_rsp1_valid(wr_rsp1_valid), .wr_rsp1_mdata(wr_rsp1_mdata),
    .wr_en(wr_en), .wr_direct(wr_direct), .wr_now(wr_now),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mdata(wr_mdata),
    .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_real_valid(wr_real_valid),
    .outstanding(outstanding),
`ifdef WCB_WMASK_OUT_EN
    .wr_req_wmask(wr_req_wmask),
`endif
    .idle(idle)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_issue  = 0;
  int n_wvalid = 0;

  always @(negedge clk) begin
    if (wr_req_en) n_issue  <= n_issue + 1;
    if (wr_valid)  n_wvalid <= n_wvalid + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    wr_req_almostfull = 1'b0;
    wr_rsp0_valid = 1'b0; wr_rsp1_valid = 1'b0;
    wr_rsp0_mdata = '0;   wr_rsp1_mdata = '0;
    wr_en = 1'b0; wr_direct = 1'b0; wr_now = 1'b0;
    wr_addr = '0; wr_data = '0; wr_mdata = '0;
  endtask

  task automatic drive_word(input logic [AW-1:0] line, input logic [OW-1:0] off, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_direct = 1'b0;
    wr_addr = {line, off};
    wr_data = '0; wr_data[DW-1:0] = d;
    wr_mdata = MW'(off);
  endtask

  task automatic drive_direct(input logic [AW-1:0] line, input logic [CW-1:0] d, input logic [MW-1:0] md);
    wr_en = 1'b0; wr_direct = 1'b1;
    wr_addr = {line, 4'h0}; wr_data = d; wr_mdata = md;
  endtask

  task automatic pulse_rsp(input logic r0, input logic r1);
    wr_rsp0_valid = r0; wr_rsp1_valid = r1;
    tick;
    wr_rsp0_valid = 1'b0; wr_rsp1_valid = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    n_checks++; if (wr_req_en !== 1'b0) begin n_fail++; $display("FAIL reset_req_en: got %0b want 0", wr_req_en); end
    n_checks++; if (wr_req_addr !== '0) begin n_fail++; $display("FAIL reset_req_addr: got %h want 0", wr_req_addr); end
    n_checks++; if (wr_req_data !== '0) begin n_fail++; $display("FAIL reset_req_data: got %h want 0", wr_req_data); end
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %0b want 0", wr_valid); end
    n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %0b want 1", idle); end
    wr_rsp0_valid = 1'b1; wr_rsp1_valid = 1'b1;
    #1;
    n_checks++; if (wr_real_valid !== 1'b1) begin n_fail++; $display("FAIL real_valid: got %0b want 1", wr_real_valid); end
    tick;
    wr_rsp0_valid = 1'b0; wr_rsp1_valid = 1'b0;
    n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL rsp_underflow: got %0d want 0", outstanding); end
  endtask

  task automatic test_fill_line;
    logic [CW-1:0] exp;
    int w0, i0;
    exp = '0; w0 = n_wvalid; i0 = n_issue;
    for (int i = 0; i < WPL; i++) begin
      drive_word(20'h5, OW'(i), 32'hA500_0000 + 32'(i));
      exp[i*DW +: DW] = 32'hA500_0000 + 32'(i);
      #1;
      n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %0b want 1", i, wr_ready); end
      tick;
    end
    wr_en = 1'b0;
    n_checks++; if (wr_req_en !== 1'b0) begin n_fail++; $display("FAIL fill_early: got %0b want 0", wr_req_en); end
    tick;
    n_checks++; if (wr_req_en !== 1'b1) begin n_fail++; $display("FAIL fill_latency: got %0b want 1", wr_req_en); end
    n_checks++; if (wr_req_addr !== 20'h5) begin n_fail++; $display("FAIL fill_addr: got %h want 5", wr_req_addr); end
    n_checks++; if (wr_req_data !== exp) begin n_fail++; $display("FAIL fill_data: got %h want %h", wr_req_data, exp); end
    n_checks++; if (wr_req_mdata !== 14'd15) begin n_fail++; $display("FAIL fill_mdata: got %0d want 15", wr_req_mdata); end
    n_checks++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL fill_outstanding: got %0d want 1", outstanding); end
    tick; tick;
    n_checks++; if (n_issue - i0 !== 1) begin n_fail++; $display("FAIL fill_issue_count: got %0d want 1", n_issue - i0); end
    n_checks++; if (n_wvalid - w0 !== 16) begin n_fail++; $display("FAIL fill_wvalid_count: got %0d want 16", n_wvalid - w0); end
    pulse_rsp(1'b1, 1'b0);
    n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL fill_rsp: got %0d want 0", outstanding); end
  endtask

  task automatic test_victim;
    logic [CW-1:0] exp;
    for (int k = 1; k <= 4; k++) begin
      drive_word(AW'(k), 4'd3, 32'(k * 17));
      #1;
      n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL victim_fill_ready[%0d]: got %0b want 1", k, wr_ready); end
      tick;
    end
    drive_word(20'h6, 4'd0, 32'h66);
    #1;
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL victim_stall: got %0b want 0", wr_ready); end
    tick;
    exp = '0; exp[3*DW +: DW] = 32'd17;
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL victim_accept: got %0b want 1", wr_ready); end
    n_checks++; if (wr_req_en !== 1'b1) begin n_fail++; $display("FAIL victim_issue: got %0b want 1", wr_req_en); end
    n_checks++; if (wr_req_addr !== 20'h1) begin n_fail++; $display("FAIL victim_addr: got %h want 1", wr_req_addr); end
    n_checks++; if (wr_req_data !== exp) begin n_fail++; $display("FAIL victim_data: got %h want %h", wr_req_data, exp); end
    tick;
    wr_en = 1'b0;
    n_checks++; if (wr_req_en !== 1'b0) begin n_fail++; $display("FAIL victim_single: got %0b want 0", wr_req_en); end
  endtask

  // Drains the four slots left by test_victim with a response every cycle,
  // so issue and response cancel in the credit counter.
  task automatic test_flush_drain;
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 20'h6; exp_a[1] = 20'h2; exp_a[2] = 20'h3; exp_a[3] = 20'h4;
    wr_rsp0_valid = 1'b1; wr_now = 1'b1;
    tick;
    wr_now = 1'b0;
    tick;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (wr_req_en !== 1'b1 || wr_req_addr !== exp_a[k]) begin n_fail++; $display("FAIL drain_order[%0d]: got en=%0b addr=%h want en=1 addr=%h", k, wr_req_en, wr_req_addr, exp_a[k]); end
      n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL drain_net[%0d]: got %0d want 0", k, outstanding); end
      tick;
    end
    wr_rsp0_valid = 1'b0;
    n_checks++; if (wr_req_en !== 1'b0) begin n_fail++; $display("FAIL drain_end: got %0b want 0", wr_req_en); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL drain_idle: got %0b want 1", idle); end
  endtask

  task automatic test_flush;
    int w0;
    w0 = n_wvalid;
    drive_word(20'hA, 4'd1, 32'hAAAA_0001); tick;
    drive_word(20'hB, 4'd2, 32'hBBBB_0002); tick;
    wr_en = 1'b0; wr_now = 1'b1;
    tick;
    wr_now = 1'b0;
    drive_word(20'hC, 4'd0, 32'hCCCC);
    #1;
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0b want 0", wr_ready); end
    tick;
    wr_en = 1'b0;
    n_checks++; if (wr_req_en !== 1'b1 || wr_req_addr !== 20'hA) begin n_fail++; $display("FAIL flush_first: got en=%0b addr=%h want en=1 addr=a", wr_req_en, wr_req_addr); end
    n_checks++; if (wr_req_data[2*DW-1:DW] !== 32'hAAAA_0001) begin n_fail++; $display("FAIL flush_partial: got %h want aaaa0001", wr_req_data[2*DW-1:DW]); end
    tick;
    n_checks++; if (wr_req_en !== 1'b1 || wr_req_addr !== 20'hB) begin n_fail++; $display("FAIL flush_second: got en=%0b addr=%h want en=1 addr=b", wr_req_en, wr_req_addr); end
    tick;
    n_checks++; if (wr_req_en !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %0b want 0", wr_req_en); end
    n_checks++; if (outstanding !== 2'd2 || idle !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got out=%0d idle=%0b want out=2 idle=0", outstanding, idle); end
    n_checks++; if (n_wvalid - w0 !== 2) begin n_fail++; $display("FAIL flush_reject: got %0d want 2", n_wvalid - w0); end
    drive_word(20'hD, 4'd0, 32'h1);
    #1;
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL flush_back_run: got %0b want 1", wr_ready); end
    wr_en = 1'b0;
    pulse_rsp(1'b1, 1'b1);
    n_checks++; if (outstanding !== 2'd0 || idle !== 1'b1) begin n_fail++; $display("FAIL flush_idle: got out=%0d idle=%0b want out=0 idle=1", outstanding, idle); end
  endtask

  task automatic test_direct;
    logic [CW-1:0] dd, exp;
    for (int i = 0; i < WPL; i++) dd[i*DW +: DW] = 32'hD000_0000 + 32'(i);
    exp = '0; exp[DW-1:0] = 32'h99;
    drive_word(20'h9, 4'd0, 32'h99); tick;
    drive_direct(20'h9, dd, 14'h1234);
    #1;
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL direct_hit_stall: got %0b want 0", wr_ready); end
    tick;
    n_checks++; if (wr_req_en !== 1'b1 || wr_req_addr !== 20'h9 || wr_req_data !== exp) begin n_fail++; $display("FAIL direct_old_first: got en=%0b addr=%h data=%h", wr_req_en, wr_req_addr, wr_req_data); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL direct_ready: got %0b want 1", wr_ready); end
    tick;
    wr_direct = 1'b0;
    n_checks++; if (wr_req_en !== 1'b1 || wr_req_data !== dd) begin n_fail++; $display("FAIL direct_pass: got en=%0b data=%h want %h", wr_req_en, wr_req_data, dd); end
    n_checks++; if (wr_req_mdata !== 14'h1234) begin n_fail++; $display("FAIL direct_mdata: got %h want 1234", wr_req_mdata); end
    n_checks++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL direct_out: got %0d want 2", outstanding); end
    pulse_rsp(1'b1, 1'b1);
  endtask

  task automatic test_almostfull;
    wr_req_almostfull = 1'b1;
    for (int i = 0; i < WPL; i++) begin drive_word(20'h7, OW'(i), 32'(i)); tick; end
    drive_direct(20'h20, '1, '0);
    #1;
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL af_direct_held: got %0b want 0", wr_ready); end
    wr_direct = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      n_checks++; if (wr_req_en !== 1'b0) begin n_fail++; $display("FAIL af_blocked[%0d]: got %0b want 0", i, wr_req_en); end
    end
    wr_req_almostfull = 1'b0;
    tick;
    n_checks++; if (wr_req_en !== 1'b1 || wr_req_addr !== 20'h7) begin n_fail++; $display("FAIL af_release: got en=%0b addr=%h want en=1 addr=7", wr_req_en, wr_req_addr); end
    tick;
    pulse_rsp(1'b1, 1'b0);
  endtask

  task automatic test_credit;
    drive_direct(20'h30, '1, 14'd1);
    #1;
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL credit_ready0: got %0b want 1", wr_ready); end
    tick;
    drive_direct(20'h31, '1, 14'd2);
    #1;
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL credit_ready1: got %0b want 1", wr_ready); end
    tick;
    n_checks++; if (wr_req_addr !== 20'h31) begin n_fail++; $display("FAIL credit_second: got %h want 31", wr_req_addr); end
    for (int i = 0; i < WPL; i++) begin drive_word(20'h32, OW'(i), 32'h3200 + 32'(i)); tick; end
    drive_direct(20'h33, '1, '0);
    #1;
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL credit_direct_held: got %0b want 0", wr_ready); end
    wr_direct = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++; if (wr_req_en !== 1'b0 || outstanding !== 2'd2) begin n_fail++; $display("FAIL credit_stall[%0d]: got en=%0b out=%0d want en=0 out=2", i, wr_req_en, outstanding); end
    end
    pulse_rsp(1'b1, 1'b1);
    n_checks++; if (outstanding !== 2'd0 || wr_req_en !== 1'b0) begin n_fail++; $display("FAIL credit_return: got out=%0d en=%0b want out=0 en=0", outstanding, wr_req_en); end
    tick;
    n_checks++; if (wr_req_en !== 1'b1 || wr_req_addr !== 20'h32 || outstanding !== 2'd1) begin n_fail++; $display("FAIL credit_resume: got en=%0b addr=%h out=%0d want en=1 addr=32 out=1", wr_req_en, wr_req_addr, outstanding); end
    tick;
    pulse_rsp(1'b1, 1'b0);
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL credit_idle: got %0b want 1", idle); end
  endtask

  initial begin
    test_reset();
    test_fill_line();
    test_victim();
    test_flush_drain();
    test_flush();
    test_direct();
    test_almostfull();
    test_credit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
